// File: rtl/clk_divider_bank.sv
// Bank of independent programmable half-period dividers producing registered
// square waves and one-cycle rise/fall strobes for use as clock enables.
module clk_divider_bank #(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 27,
   parameter int DEFAULT_HALF = 833333
) (
   input  logic                    clk_in,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH*CNT_W-1:0] div_half,
   input  logic                    sync,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       tick_rise,
   output logic [NUM_CH-1:0]       tick_fall
);

   logic [CNT_W-1:0]  cnt_r  [NUM_CH];
   logic [CNT_W-1:0]  half_r [NUM_CH];
   logic [CNT_W-1:0]  cnt_s  [NUM_CH];
   logic [CNT_W-1:0]  half_s [NUM_CH];
   logic [NUM_CH-1:0] clk_s;
   logic [NUM_CH-1:0] rise_s;
   logic [NUM_CH-1:0] fall_s;

   // Next-state for every channel: sync > stopped > wrap > count
   always_comb begin
      cnt_s  = cnt_r;
      half_s = half_r;
      clk_s  = clk_out;
      rise_s = {NUM_CH{1'b0}};
      fall_s = {NUM_CH{1'b0}};
      for (int k = 0; k < NUM_CH; k++) begin
         if (sync) begin
            cnt_s[k]  = {CNT_W{1'b0}};
            clk_s[k]  = 1'b0;
            half_s[k] = div_half[k*CNT_W +: CNT_W];
            fall_s[k] = clk_out[k];
         end else if (!en[k]) begin
            half_s[k] = div_half[k*CNT_W +: CNT_W];
         end else if (cnt_r[k] >= half_r[k]) begin
            // >= also recovers a counter left above a divisor shrunk while stopped
            cnt_s[k]  = {CNT_W{1'b0}};
            clk_s[k]  = ~clk_out[k];
            half_s[k] = div_half[k*CNT_W +: CNT_W];
            rise_s[k] = ~clk_out[k];
            fall_s[k] = clk_out[k];
         end else begin
            cnt_s[k] = cnt_r[k] + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // State and output registers with asynchronous clear
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NUM_CH; k++) begin
            cnt_r[k]  <= {CNT_W{1'b0}};
            half_r[k] <= CNT_W'(DEFAULT_HALF);
         end
         clk_out   <= {NUM_CH{1'b0}};
         tick_rise <= {NUM_CH{1'b0}};
         tick_fall <= {NUM_CH{1'b0}};
      end else begin
         cnt_r     <= cnt_s;
         half_r    <= half_s;
         clk_out   <= clk_s;
         tick_rise <= rise_s;
         tick_fall <= fall_s;
      end
   end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed bench for clk_divider_bank: table of per-channel period checks plus
// hand sequences for divisor change, sync, stop/resume and async reset.
module tb_clk_divider_bank;

   localparam int NCH = 4;
   localparam int CW  = 8;
   localparam int DEF = 261;   // truncates to 5 in an 8-bit shadow

   logic            clk_in = 1'b0;
   logic            reset;
   logic [NCH-1:0]  en;
   logic [NCH*CW-1:0] div_half;
   logic            sync;
   logic [NCH-1:0]  clk_out, tick_rise, tick_fall;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   clk_divider_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_HALF(DEF)) dut (
      .clk_in(clk_in), .reset(reset), .en(en), .div_half(div_half), .sync(sync),
      .clk_out(clk_out), .tick_rise(tick_rise), .tick_fall(tick_fall)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int ch;
      int half;
      int first;
      int period;
      int high;
   } vec_t;

   vec_t tbl [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_in);
      cyc++;
   endtask

   task automatic set_div(input int ch, input int val);
      div_half[ch*CW +: CW] = val[CW-1:0];
   endtask

   task automatic do_sync();
      sync = 1'b1;
      step();
      sync = 1'b0;
   endtask

   initial begin
      int t1, t2, hi, terr, r0, r1, ferr;
      logic c, p;

      tbl[0] = '{0, 3, 4, 8, 4};
      tbl[1] = '{1, 0, 1, 2, 1};
      tbl[2] = '{2, 5, 6, 12, 6};
      tbl[3] = '{3, 255, 256, 512, 256};

      reset = 1'b0; en = '0; div_half = '0; sync = 1'b0;
      #2;
      check("reset_clk_out", 32'(clk_out), 32'd0);
      check("reset_ticks", 32'({tick_rise, tick_fall}), 32'd0);
      step();
      reset = 1'b1;

      // Table: period, high time, first rise and strobe shape per channel
      for (int v = 0; v < 4; v++) begin
         en = 4'hF;
         for (int j = 0; j < NCH; j++) set_div(j, 1);
         set_div(tbl[v].ch, tbl[v].half);
         do_sync();
         p = clk_out[tbl[v].ch];
         t1 = -1; t2 = -1; hi = 0; terr = 0;
         for (int i = 1; i <= 1100 && t2 < 0; i++) begin
            step();
            c = clk_out[tbl[v].ch];
            if (c && !p) begin
               if (t1 < 0) t1 = i;
               else        t2 = i;
            end
            if (t1 >= 0 && t2 < 0 && c) hi++;
            if (tick_rise[tbl[v].ch] !== (c & ~p)) terr++;
            if (tick_fall[tbl[v].ch] !== (~c & p)) terr++;
            p = c;
         end
         check($sformatf("first_rise_ch%0d", tbl[v].ch), 32'(t1), 32'(tbl[v].first));
         check($sformatf("period_ch%0d", tbl[v].ch), 32'(t2 - t1), 32'(tbl[v].period));
         check($sformatf("high_ch%0d", tbl[v].ch), 32'(hi), 32'(tbl[v].high));
         check($sformatf("tick_shape_ch%0d", tbl[v].ch), 32'(terr), 32'd0);
      end

      // Divisor change mid half-period waits for the next wrap
      en = 4'b0001; set_div(0, 3);
      do_sync();
      step(); step();
      set_div(0, 9);
      r0 = -1; r1 = -1; t2 = -1; p = clk_out[0];
      for (int i = 3; i <= 40 && t2 < 0; i++) begin
         step();
         if (clk_out[0] && !p) begin
            if (r0 < 0) r0 = i; else t2 = i;
         end
         if (!clk_out[0] && p && r1 < 0) r1 = i;
         p = clk_out[0];
      end
      check("chg_rise", 32'(r0), 32'd4);
      check("chg_fall", 32'(r1), 32'd14);
      check("chg_rise2", 32'(t2), 32'd24);

      // Sync while free-running: fall strobe only where output was high
      en = 4'b0011; set_div(0, 4); set_div(1, 6);
      do_sync();
      for (int i = 0; i < 12; i++) step();
      check("pre_sync_level", 32'(clk_out[1:0]), 32'd2);
      do_sync();
      check("sync_clk_out", 32'(clk_out[1:0]), 32'd0);
      check("sync_tick_fall", 32'(tick_fall[1:0]), 32'd2);
      check("sync_tick_rise", 32'(tick_rise[1:0]), 32'd0);
      r0 = -1; r1 = -1;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (clk_out[0] && r0 < 0) r0 = i;
         if (clk_out[1] && r1 < 0) r1 = i;
      end
      check("sync_rise_ch0", 32'(r0), 32'd5);
      check("sync_rise_ch1", 32'(r1), 32'd7);

      // Stop while high mid-count, hold, then resume the remainder
      en = 4'b0100; set_div(2, 5);
      do_sync();
      for (int i = 0; i < 8; i++) step();
      check("stop_pre_level", 32'(clk_out[2]), 32'd1);
      en[2] = 1'b0;
      ferr = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (clk_out[2] !== 1'b1 || tick_rise[2] !== 1'b0 || tick_fall[2] !== 1'b0) ferr++;
      end
      check("stop_frozen", 32'(ferr), 32'd0);
      en[2] = 1'b1;
      step(); step(); step();
      check("resume_still_high", 32'(clk_out[2]), 32'd1);
      step();
      check("resume_fall", 32'(clk_out[2]), 32'd0);
      check("resume_tick_fall", 32'(tick_fall[2]), 32'd1);

      // Asynchronous reset between edges, then default shadow divisor
      en = 4'hF;
      for (int j = 0; j < NCH; j++) set_div(j, 1);
      set_div(0, 0);
      do_sync();
      step();
      check("pre_reset_level", 32'(clk_out[0]), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async_clk_out", 32'(clk_out), 32'd0);
      check("async_ticks", 32'({tick_rise, tick_fall}), 32'd0);
      en = 4'b0001; set_div(0, 2);
      step();
      reset = 1'b1;
      r0 = -1; r1 = -1;
      for (int i = 1; i <= 30 && r1 < 0; i++) begin
         step();
         if (clk_out[0] && r0 < 0) r0 = i;
         if (!clk_out[0] && r0 >= 0 && r1 < 0) r1 = i;
      end
      check("default_first_rise", 32'(r0), 32'd6);
      check("reload_fall", 32'(r1), 32'd9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
